uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding
// and the default sizing constants used by the arbiter and its bench.
package uart_pkg;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_MAX_BURST    = 16;
    localparam int DEF_IDLE_TIMEOUT = 1024;

    // One-hot style encoding so that any corrupted value is detectably
    // different from both legal states and falls into the recovery arm.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_OWN  = 2'b10
    } arb_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: returns a one-hot winner, searching
// upward from index ptr and wrapping around to index 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

    logic found;

    // First pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// Arbiter granting one of N_REQ byte streams access to a single UART
// transmitter. A grant lasts until end of message, MAX_BURST bytes, or
// IDLE_TIMEOUT stalled cycles, after which priority moves to the next index.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BEAT_W  = $clog2(MAX_BURST + 1);
    localparam int STALL_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(IDLE_TIMEOUT - 1);
    localparam logic [PTR_W-1:0]   PTR_MAX    = PTR_W'(N_REQ - 1);

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner_idx;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [STALL_W-1:0] stall_cnt;

    logic [N_REQ-1:0]   pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               owner_valid;
    logic               owner_last;
    logic               beat;
    logic [PTR_W-1:0]   ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt)
    );

    // Binary index of the selected requester, remembered for the ptr update.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) pick_idx = PTR_W'(i);
        end
    end

    // Owner pass-through: only the granted requester reaches the transmitter.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                tx_valid = req_valid[i];
                tx_data  = req_data[8*i +: 8];
            end
        end
    end

    // grant is all-zero outside OWN, so non-owners and IDLE always see 0.
    assign req_ready   = grant & {N_REQ{tx_ready}};
    assign owner_valid = |(req_valid & grant);
    assign owner_last  = |(req_last & grant);
    assign beat        = tx_valid & tx_ready;
    assign ptr_next    = (owner_idx == PTR_MAX) ? '0 : owner_idx + 1'b1;
    assign busy        = (state == ST_OWN);

    // Arbitration FSM with grant, ptr and burst/stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here is control state and is reset; state is
        // updated with non-blocking assignments so all registers see the
        // values from the same edge regardless of statement order.
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant     <= '0;
            owner_idx <= '0;
            ptr       <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    beat_cnt  <= '0;
                    stall_cnt <= '0;
                    if (|req_valid) begin
                        grant     <= pick_gnt;
                        owner_idx <= pick_idx;
                        state     <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (beat) begin
                        stall_cnt <= '0;
                        if (owner_last || (beat_cnt == BEAT_LAST)) begin
                            state <= ST_IDLE;
                            grant <= '0;
                            ptr   <= ptr_next;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (!owner_valid) begin
                        if (stall_cnt == STALL_LAST) begin
                            state <= ST_IDLE;
                            grant <= '0;
                            ptr   <= ptr_next;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        // Owner is presenting a byte; transmitter is busy.
                        stall_cnt <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule : uart_tx_arbiter
